// File: rtl/cios_reduce_row_pkg.sv
// cios_reduce_row_pkg: shared FSM state encoding and default word types for the CIOS reduction row
package cios_pkg;
  localparam int CIOS_W = 32;
  localparam int CIOS_S = 4;
  typedef logic [CIOS_W-1:0] word_t;
  typedef logic [2*CIOS_W-1:0] dword_t;
  typedef enum logic [2:0] {IDLE, CALC_M, LOOP, TOP, DONE} state_t;
endpackage

// File: rtl/cios_reduce_row_mac.sv
// cios_mac: combinational a*b + c + d, the single W x W multiplier of the reduction row
module cios_mac #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  input  logic [W-1:0]   d,
  output logic [2*W-1:0] r
);
  // the sum never overflows 2W bits: (2^W-1)^2 + 2(2^W-1) = 2^2W - 1
  always_comb r = {{W{1'b0}}, a} * {{W{1'b0}}, b} + {{W{1'b0}}, c} + {{W{1'b0}}, d};
endmodule

// File: rtl/cios_reduce_row.sv
// cios_reduce_row: one CIOS Montgomery reduction row, T' = (T + m*p) / 2^W, one word per cycle
module cios_reduce_row
  import cios_pkg::*;
#(
  parameter int W = 32,
  parameter int S = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               use_ext_m,
  input  logic [W-1:0]       m_in,
  input  logic [W-1:0]       n_prime,
  input  logic [S*W-1:0]     p,
  input  logic [(S+2)*W-1:0] t_in,
  output logic [(S+2)*W-1:0] t_out,
  output logic [W-1:0]       m_out,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(S+1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [(S+2)*W-1:0] t_q, t_d, tout_q, tout_d;
  logic [S*W-1:0] p_q, p_d;
  logic [W-1:0] np_q, np_d, m_q, m_d, c_q, c_d, mout_q, mout_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [W-1:0] mac_a, mac_b, mac_c, mac_d, s_top;
  logic [2*W-1:0] mac_r;
  logic c1;
  // CALC_M borrows the MAC for T[0]*n_prime; LOOP feeds it word j of the latched operands
  always_comb begin
    mac_a = (state_q == CALC_M) ? t_q[W-1:0] : m_q;
    mac_b = (state_q == CALC_M) ? np_q : p_q[int'(cnt_q)*W +: W];
    mac_c = (state_q == CALC_M) ? '0 : t_q[int'(cnt_q)*W +: W];
    mac_d = (state_q == CALC_M) ? '0 : c_q;
  end
  cios_mac #(.W(W)) u_mac (.a(mac_a), .b(mac_b), .c(mac_c), .d(mac_d), .r(mac_r));
  assign {c1, s_top} = {1'b0, t_q[S*W +: W]} + {1'b0, c_q};
  // next state; T' overwrites T in place since word j-1 is dead once step j runs
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    t_d = t_q;
    p_d = p_q;
    np_d = np_q;
    m_d = m_q;
    c_d = c_q;
    tout_d = tout_q;
    mout_d = mout_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        t_d = t_in;
        p_d = p;
        np_d = n_prime;
        m_d = m_in;
        c_d = '0;
        cnt_d = '0;
        busy_d = 1'b1;
        state_d = use_ext_m ? LOOP : CALC_M;
      end
      CALC_M: begin
        m_d = mac_r[W-1:0];
        state_d = LOOP;
      end
      LOOP: begin
        c_d = mac_r[2*W-1:W];
        if (cnt_q != '0) t_d[(int'(cnt_q)-1)*W +: W] = mac_r[W-1:0];
        cnt_d = (cnt_q == CW'(S-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(S-1)) ? TOP : LOOP;
      end
      TOP: begin
        t_d[(S-1)*W +: W] = s_top;
        t_d[S*W +: W] = t_q[(S+1)*W +: W] + {{(W-1){1'b0}}, c1};
        t_d[(S+1)*W +: W] = '0;
        tout_d = t_d;
        mout_d = m_q;
        busy_d = 1'b0;
        done_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // all state and registered outputs, cleared synchronously on rst
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      t_q <= '0;
      p_q <= '0;
      np_q <= '0;
      m_q <= '0;
      c_q <= '0;
      tout_q <= '0;
      mout_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      t_q <= t_d;
      p_q <= p_d;
      np_q <= np_d;
      m_q <= m_d;
      c_q <= c_d;
      tout_q <= tout_d;
      mout_q <= mout_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign t_out = tout_q;
  assign m_out = mout_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
